// File: rtl/exe_pkg.sv
// ============================================================
// exe_pkg: ALU opcodes, destination-select codes, link register
// rev 1.0
// ============================================================
`default_nettype none

package exe_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD   = 4'd0;
   localparam alu_op_t ALU_SUB   = 4'd1;
   localparam alu_op_t ALU_AND   = 4'd2;
   localparam alu_op_t ALU_OR    = 4'd3;
   localparam alu_op_t ALU_XOR   = 4'd4;
   localparam alu_op_t ALU_NOT   = 4'd5;
   localparam alu_op_t ALU_SLL   = 4'd6;
   localparam alu_op_t ALU_SRL   = 4'd7;
   localparam alu_op_t ALU_LLB   = 4'd8;
   localparam alu_op_t ALU_LHB   = 4'd9;
   localparam alu_op_t ALU_ADDI  = 4'd10;
   localparam alu_op_t ALU_PASSB = 4'd11;

   localparam logic [1:0] REG_DST_RD   = 2'd0;
   localparam logic [1:0] REG_DST_RT   = 2'd1;
   localparam logic [1:0] REG_DST_RS   = 2'd2;
   localparam logic [1:0] REG_DST_LINK = 2'd3;

   localparam logic [2:0] LINK_REG = 3'd7;

   // Two's-complement overflow of r = x + y, given the sign bits.
   function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
      return (x_msb == y_msb) && (r_msb != x_msb);
   endfunction

endpackage

`default_nettype wire

// File: rtl/exe_alu.sv
// ============================================================
// exe_alu: combinational 16-bit ALU; ovf port under EXE_FLAGS_EN
// rev 1.0
// ============================================================
`default_nettype none

module exe_alu
   import exe_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [7:0]        lb,
   input  logic [DATA_W-1:0] se,
`ifdef EXE_FLAGS_EN
   output logic              ovf,
`endif
   output logic [DATA_W-1:0] result
);

   localparam int MSB = DATA_W - 1;

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOT:   result = ~a;
         ALU_SLL:   result = a << b[3:0];
         ALU_SRL:   result = a >> b[3:0];
         ALU_LLB:   result = {{(DATA_W-8){1'b0}}, lb};
         ALU_LHB:   result = {lb, a[DATA_W-9:0]};
         ALU_ADDI:  result = a + se;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

`ifdef EXE_FLAGS_EN
   // Subtraction overflows like a + (-b): operand signs must differ.
   always_comb begin
      ovf = 1'b0;
      case (op)
         ALU_ADD:  ovf = add_ovf(a[MSB], b[MSB], result[MSB]);
         ALU_SUB:  ovf = add_ovf(a[MSB], ~b[MSB], result[MSB]);
         ALU_ADDI: ovf = add_ovf(a[MSB], se[MSB], result[MSB]);
         default:  ovf = 1'b0;
      endcase
   end
`endif

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================
// exe_stage: forwarding, ALU, gt/le branch, load-use stall, EX/MEM
// register; EXE_FLAGS_EN adds mem_zero/mem_neg/mem_ovf. rev 1.0
// ============================================================
`default_nettype none

module exe_stage
   import exe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int PC_W   = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PC_W-1:0]   exe_bra_pc,
   input  logic [DATA_W-1:0] exe_reg1_val,
   input  logic [DATA_W-1:0] exe_reg2_val,
   input  logic [REG_AW-1:0] exe_rs,
   input  logic [REG_AW-1:0] exe_rt,
   input  logic [REG_AW-1:0] exe_rd,
   input  logic [7:0]        exe_lb_const,
   input  logic [DATA_W-1:0] exe_se_const,
   input  logic              exe_gt_bra,
   input  logic              exe_le_bra,
   input  logic [3:0]        exe_alu_op,
   input  logic [1:0]        exe_reg_dst,
   input  logic              exe_mem_read,
   input  logic              exe_mem_write,
   input  logic              exe_memtoreg,
   input  logic              exe_regwrite,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              bra_taken,
   output logic [PC_W-1:0]   bra_target,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_store_val,
   output logic [REG_AW-1:0] mem_dst,
`ifdef EXE_FLAGS_EN
   output logic              mem_zero,
   output logic              mem_neg,
   output logic              mem_ovf,
`endif
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic              mem_memtoreg,
   output logic              mem_regwrite
);

   logic [DATA_W-1:0] op_a, op_b, alu_res;
   logic [REG_AW-1:0] dst;
   logic              mem_fwd_ok, a_gt_b;
`ifdef EXE_FLAGS_EN
   logic              alu_ovf;
`endif

   // A load in EX/MEM has no data yet; it is only forwardable once in WB.
   assign mem_fwd_ok = mem_regwrite & ~mem_mem_read;

   always_comb begin
      if (mem_fwd_ok && mem_dst == exe_rs)      op_a = mem_alu_result;
      else if (wb_regwrite && wb_dst == exe_rs) op_a = wb_data;
      else                                      op_a = exe_reg1_val;

      if (mem_fwd_ok && mem_dst == exe_rt)      op_b = mem_alu_result;
      else if (wb_regwrite && wb_dst == exe_rt) op_b = wb_data;
      else                                      op_b = exe_reg2_val;
   end

   always_comb begin
      dst = exe_rd;
      case (exe_reg_dst)
         REG_DST_RD:   dst = exe_rd;
         REG_DST_RT:   dst = exe_rt;
         REG_DST_RS:   dst = exe_rs;
         REG_DST_LINK: dst = LINK_REG;
         default:      dst = exe_rd;
      endcase
   end

   exe_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (exe_alu_op),
      .a      (op_a),
      .b      (op_b),
      .lb     (exe_lb_const),
      .se     (exe_se_const),
`ifdef EXE_FLAGS_EN
      .ovf    (alu_ovf),
`endif
      .result (alu_res)
   );

   assign stall = ~reset & mem_mem_read & mem_regwrite &
                  ((mem_dst == exe_rs) | (mem_dst == exe_rt));

   assign a_gt_b     = $signed(op_a) > $signed(op_b);
   assign bra_taken  = ~reset & ~stall &
                       ((exe_gt_bra & a_gt_b) | (exe_le_bra & ~a_gt_b));
   assign bra_target = exe_bra_pc;

   always_ff @(posedge clock) begin
      if (reset || stall) begin
         mem_alu_result <= '0;
         mem_store_val  <= '0;
         mem_dst        <= '0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_memtoreg   <= 1'b0;
         mem_regwrite   <= 1'b0;
`ifdef EXE_FLAGS_EN
         mem_zero       <= 1'b0;
         mem_neg        <= 1'b0;
         mem_ovf        <= 1'b0;
`endif
      end else begin
         mem_alu_result <= alu_res;
         mem_store_val  <= op_b;
         mem_dst        <= dst;
         mem_mem_read   <= exe_mem_read;
         mem_mem_write  <= exe_mem_write;
         mem_memtoreg   <= exe_memtoreg;
         mem_regwrite   <= exe_regwrite;
`ifdef EXE_FLAGS_EN
         mem_zero       <= (alu_res == '0);
         mem_neg        <= alu_res[DATA_W-1];
         mem_ovf        <= alu_ovf;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================
// Module  : tb_exe_stage
// Brief   : directed vectors, queue scoreboard, negedge monitor,
//           reset-state check and expired-wait check
// Revision: rev 1.1
// ============================================================
`default_nettype none

module tb_exe_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  exe_bra_pc;
    logic [15:0] exe_reg1_val, exe_reg2_val, exe_se_const, wb_data;
    logic [2:0]  exe_rs, exe_rt, exe_rd, wb_dst;
    logic [7:0]  exe_lb_const;
    logic        exe_gt_bra, exe_le_bra;
    logic [3:0]  exe_alu_op;
    logic [1:0]  exe_reg_dst;
    logic        exe_mem_read, exe_mem_write, exe_memtoreg, exe_regwrite, wb_regwrite;
    logic        stall, bra_taken;
    logic [5:0]  bra_target;
    logic [15:0] mem_alu_result, mem_store_val;
    logic [2:0]  mem_dst;
    logic        mem_mem_read, mem_mem_write, mem_memtoreg, mem_regwrite;
`ifdef EXE_FLAGS_EN
    logic        mem_zero, mem_neg, mem_ovf;
`endif

    localparam int C_TIMEOUT = 100000;

    always #5 clock = ~clock;

    exe_stage #(.DATA_W(16), .REG_AW(3), .PC_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .exe_bra_pc     (exe_bra_pc),
        .exe_reg1_val   (exe_reg1_val),
        .exe_reg2_val   (exe_reg2_val),
        .exe_rs         (exe_rs),
        .exe_rt         (exe_rt),
        .exe_rd         (exe_rd),
        .exe_lb_const   (exe_lb_const),
        .exe_se_const   (exe_se_const),
        .exe_gt_bra     (exe_gt_bra),
        .exe_le_bra     (exe_le_bra),
        .exe_alu_op     (exe_alu_op),
        .exe_reg_dst    (exe_reg_dst),
        .exe_mem_read   (exe_mem_read),
        .exe_mem_write  (exe_mem_write),
        .exe_memtoreg   (exe_memtoreg),
        .exe_regwrite   (exe_regwrite),
        .wb_regwrite    (wb_regwrite),
        .wb_dst         (wb_dst),
        .wb_data        (wb_data),
        .stall          (stall),
        .bra_taken      (bra_taken),
        .bra_target     (bra_target),
        .mem_alu_result (mem_alu_result),
        .mem_store_val  (mem_store_val),
        .mem_dst        (mem_dst),
`ifdef EXE_FLAGS_EN
        .mem_zero       (mem_zero),
        .mem_neg        (mem_neg),
        .mem_ovf        (mem_ovf),
`endif
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_memtoreg   (mem_memtoreg),
        .mem_regwrite   (mem_regwrite)
    );

    typedef struct {
        int          due;
        string       name;
        bit          comb;
        bit          chk_tgt;
        logic [41:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // comb entries: {stall, bra_taken, target}; reg entries: {alu, store, dst, ctrl, flags}
    task automatic go(input string name, input logic st, input logic bt,
                      input logic chk_t, input logic [5:0] tgt,
                      input logic [15:0] alu, input logic [15:0] sv,
                      input logic [2:0] dst, input logic [3:0] ctrl, input logic [2:0] flg);
        exp_t e;
        e.due = cyc; e.name = {name, "/comb"}; e.comb = 1'b1; e.chk_tgt = chk_t;
        e.v = {34'd0, st, bt, chk_t ? tgt : 6'd0};
        q.push_back(e);
        e.due = cyc + 1; e.name = {name, "/exmem"}; e.comb = 1'b0; e.chk_tgt = 1'b0;
`ifdef EXE_FLAGS_EN
        e.v = {alu, sv, dst, ctrl, flg};
`else
        e.v = {alu, sv, dst, ctrl, 3'b000 & flg};
`endif
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t        e;
        logic [2:0]  fl;
        logic [41:0] act;
`ifdef EXE_FLAGS_EN
        fl = {mem_zero, mem_neg, mem_ovf};
`else
        fl = 3'b000;
`endif
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.comb)
                act = {34'd0, stall, bra_taken, e.chk_tgt ? bra_target : 6'd0};
            else
                act = {mem_alu_result, mem_store_val, mem_dst,
                       mem_mem_read, mem_mem_write, mem_memtoreg, mem_regwrite, fl};
            n_cmp++;
            if (e.due != cyc || act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h (cycle %0d due %0d)",
                         e.name, act, e.v, cyc, e.due);
            end
        end
    end

    task automatic clr();
        reset = 1'b0;
        exe_bra_pc = '0; exe_reg1_val = '0; exe_reg2_val = '0; exe_se_const = '0;
        exe_rs = '0; exe_rt = '0; exe_rd = '0; exe_lb_const = '0;
        exe_gt_bra = 1'b0; exe_le_bra = 1'b0; exe_alu_op = '0; exe_reg_dst = '0;
        exe_mem_read = 1'b0; exe_mem_write = 1'b0; exe_memtoreg = 1'b0; exe_regwrite = 1'b0;
        wb_regwrite = 1'b0; wb_dst = '0; wb_data = '0;
    endtask

    initial begin
        #(C_TIMEOUT);
        n_bad++;
        $display("FAIL timeout: stimulus did not complete within %0d time units", C_TIMEOUT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $display("*** TEST FAILED ***");
        $finish;
    end

    initial begin
        clr();
        reset = 1'b1;
        exe_gt_bra = 1; exe_reg1_val = 4; exe_reg2_val = 2;
        repeat (2) @(posedge clock);
        #1;

        n_cmp++;
        if (mem_alu_result !== 16'h0000 || mem_store_val !== 16'h0000 || mem_dst !== 3'd0 ||
            mem_mem_read !== 1'b0 || mem_mem_write !== 1'b0 ||
            mem_memtoreg !== 1'b0 || mem_regwrite !== 1'b0 ||
            stall !== 1'b0 || bra_taken !== 1'b0
`ifdef EXE_FLAGS_EN
            || mem_zero !== 1'b0 || mem_neg !== 1'b0 || mem_ovf !== 1'b0
`endif
           ) begin
            n_bad++;
            $display("FAIL reset_state: alu=%h store=%h dst=%h ctrl=%b%b%b%b stall=%b bra=%b",
                     mem_alu_result, mem_store_val, mem_dst,
                     mem_mem_read, mem_mem_write, mem_memtoreg, mem_regwrite,
                     stall, bra_taken);
        end

        clr(); reset = 1'b1; exe_gt_bra = 1; exe_reg1_val = 4; exe_reg2_val = 2;
        exe_regwrite = 1; exe_rd = 1;
        go("reset", 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, 4'b0000, 3'b000);

        clr(); exe_alu_op = 0; exe_rs = 2; exe_rt = 3; exe_rd = 1;
        exe_reg1_val = 5; exe_reg2_val = 3; exe_regwrite = 1;
        go("add", 0, 0, 0, 0, 16'd8, 16'd3, 3'd1, 4'b0001, 3'b000);

        clr(); exe_alu_op = 1; exe_rs = 1; exe_rt = 1; exe_rd = 2;
        exe_reg1_val = 99; exe_reg2_val = 99; exe_regwrite = 1;
        go("fwd_sub", 0, 0, 0, 0, 16'd0, 16'd8, 3'd2, 4'b0001, 3'b100);

        clr(); exe_alu_op = 10; exe_rs = 4; exe_reg1_val = 16'h0100; exe_se_const = 4;
        exe_rt = 3; exe_reg2_val = 16'h0055; exe_reg_dst = 1;
        exe_mem_read = 1; exe_memtoreg = 1; exe_regwrite = 1;
        go("lw", 0, 0, 0, 0, 16'h0104, 16'h0055, 3'd3, 4'b1011, 3'b000);

        clr(); exe_alu_op = 0; exe_rs = 3; exe_rt = 3; exe_rd = 4;
        exe_reg1_val = 1; exe_reg2_val = 1; exe_regwrite = 1; exe_le_bra = 1;
        go("lu_stall", 1, 0, 0, 0, 16'd0, 16'd0, 3'd0, 4'b0000, 3'b000);

        wb_regwrite = 1; wb_dst = 3; wb_data = 7;
        go("lu_fwd", 0, 1, 0, 0, 16'd14, 16'd7, 3'd4, 4'b0001, 3'b000);

        clr(); exe_alu_op = 1; exe_gt_bra = 1; exe_rs = 5; exe_rt = 6;
        exe_reg1_val = 16'hFFFF; exe_reg2_val = 2; exe_bra_pc = 6'h2A;
        go("bra_nt", 0, 0, 1, 6'h2A, 16'hFFFD, 16'd2, 3'd0, 4'b0000, 3'b010);

        clr(); exe_alu_op = 1; exe_gt_bra = 1; exe_rs = 5; exe_rt = 6;
        exe_reg1_val = 4; exe_reg2_val = 2; exe_bra_pc = 6'h15;
        go("bra_t", 0, 1, 1, 6'h15, 16'd2, 16'd2, 3'd0, 4'b0000, 3'b000);

        clr(); exe_alu_op = 8; exe_lb_const = 8'h0A; exe_rd = 5; exe_regwrite = 1;
        go("llb", 0, 0, 0, 0, 16'h000A, 16'h0000, 3'd5, 4'b0001, 3'b000);

        clr(); exe_alu_op = 0; exe_rs = 5; exe_rt = 5; exe_rd = 6; exe_regwrite = 1;
        exe_reg1_val = 1; exe_reg2_val = 1; wb_regwrite = 1; wb_dst = 5; wb_data = 20;
        go("prio", 0, 0, 0, 0, 16'd20, 16'd10, 3'd6, 4'b0001, 3'b000);

        clr(); exe_alu_op = 6; exe_rs = 1; exe_rt = 2; exe_reg1_val = 16'h8001;
        exe_reg2_val = 16'h0011; exe_rd = 1; exe_reg_dst = 3; exe_regwrite = 1;
        go("sll", 0, 0, 0, 0, 16'h0002, 16'h0011, 3'd7, 4'b0001, 3'b000);

        clr(); exe_alu_op = 9; exe_lb_const = 8'hAB; exe_rs = 1; exe_reg1_val = 16'h12CD;
        exe_rt = 2; exe_reg_dst = 2; exe_regwrite = 1;
        go("lhb", 0, 0, 0, 0, 16'hABCD, 16'h0000, 3'd1, 4'b0001, 3'b010);

        clr(); exe_alu_op = 13; exe_rs = 1; exe_rt = 2; exe_reg1_val = 5; exe_reg2_val = 6;
        exe_reg_dst = 1; exe_mem_write = 1;
        go("op13", 0, 0, 0, 0, 16'h0000, 16'd6, 3'd2, 4'b0100, 3'b100);

        clr(); exe_alu_op = 7; exe_rs = 3; exe_rt = 4; exe_reg1_val = 16'h8000;
        exe_reg2_val = 4; exe_rd = 3; exe_regwrite = 1;
        go("srl", 0, 0, 0, 0, 16'h0800, 16'd4, 3'd3, 4'b0001, 3'b000);

        clr(); exe_alu_op = 0; exe_rs = 5; exe_rt = 6; exe_reg1_val = 16'h7FFF;
        exe_reg2_val = 1; exe_rd = 2; exe_regwrite = 1;
        go("ovf", 0, 0, 0, 0, 16'h8000, 16'd1, 3'd2, 4'b0001, 3'b011);

        clr(); exe_alu_op = 5; exe_rs = 6; exe_rt = 7; exe_reg1_val = 16'h00FF; exe_reg2_val = 3;
        go("not", 0, 0, 0, 0, 16'hFF00, 16'd3, 3'd0, 4'b0000, 3'b010);

        clr(); exe_alu_op = 10; exe_reg1_val = 16'h0010; exe_se_const = 16'hFFFF;
        exe_rt = 3; exe_reg_dst = 1; exe_mem_read = 1; exe_memtoreg = 1; exe_regwrite = 1;
        go("lw2", 0, 0, 0, 0, 16'h000F, 16'h0000, 3'd3, 4'b1011, 3'b000);

        clr(); reset = 1'b1; exe_alu_op = 0; exe_rs = 3; exe_rt = 3; exe_rd = 4;
        exe_regwrite = 1; exe_reg1_val = 2; exe_reg2_val = 2; exe_le_bra = 1;
        go("rst_stall", 0, 0, 0, 0, 16'd0, 16'd0, 3'd0, 4'b0000, 3'b000);

        clr(); exe_alu_op = 0; exe_rs = 3; exe_rt = 3; exe_rd = 4;
        exe_regwrite = 1; exe_reg1_val = 2; exe_reg2_val = 2;
        go("post_rst", 0, 0, 0, 0, 16'd4, 16'd2, 3'd4, 4'b0001, 3'b000);

        clr();
        repeat (3) @(posedge clock);
        #1;

        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL expired_wait: %0d expectation(s) never compared, first %s due %0d",
                     q.size(), q[0].name, q[0].due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad == 0)
            $display("*** TEST PASSED ***");
        else
            $display("*** TEST FAILED ***");
        $finish;
    end

endmodule

`default_nettype wire
